// File: rtl/iopmp_err_responder_if.sv
`default_nettype none
// ============================================================================
//  Module      : iopmp_err_responder_if
//  Description : TL-UL A/D channel bundle between the IOPMP request handler
//                (master side) and the error responder (slave side).
//  Revision    : 1.0 - initial release
// ============================================================================
interface iopmp_err_responder_if #(
    parameter int SOURCE_WIDTH = 8
);
    // A channel
    logic                    a_valid;
    logic [2:0]              a_opcode;
    logic [1:0]              a_size;
    logic [SOURCE_WIDTH-1:0] a_source;
    logic [31:0]             a_address;
    logic                    a_ready;
    // D channel
    logic                    d_valid;
    logic [2:0]              d_opcode;
    logic [2:0]              d_param;
    logic [1:0]              d_size;
    logic [SOURCE_WIDTH-1:0] d_source;
    logic                    d_sink;
    logic [31:0]             d_data;
    logic                    d_error;
    logic                    d_ready;

    modport master (
        output a_valid, a_opcode, a_size, a_source, a_address, d_ready,
        input  a_ready, d_valid, d_opcode, d_param, d_size, d_source,
               d_sink, d_data, d_error
    );

    modport slave (
        input  a_valid, a_opcode, a_size, a_source, a_address, d_ready,
        output a_ready, d_valid, d_opcode, d_param, d_size, d_source,
               d_sink, d_data, d_error
    );
endinterface
`default_nettype wire

// File: rtl/iopmp_err_responder.sv
`default_nettype none
// ============================================================================
//  Module      : iopmp_err_responder
//  Description : Terminates permission-denied TL-UL requests with a single-beat
//                D response and records the first violation. The error record,
//                overflow flag and interrupt exist only when the macro
//                IOPMP_ERR_RECORD_EN is defined; otherwise they read as 0.
//                err_cfg_i[0] = ie (interrupt enable), err_cfg_i[1] = rs
//                (response suppress).
//  Revision    : 1.0 - initial release
// ============================================================================
module iopmp_err_responder #(
    parameter int ADDR_WIDTH   = 34,
    parameter int SOURCE_WIDTH = 8
) (
    input  wire logic                    clk,
    input  wire logic                    reset,
    iopmp_err_responder_if.slave         tl,
    input  wire logic                    denied_i,
    input  wire logic [SOURCE_WIDTH-1:0] rrid_i,
    input  wire logic [1:0]              err_cfg_i,
    input  wire logic                    err_clr_i,
    output logic                         err_valid_o,
    output logic                         err_ovf_o,
    output logic [ADDR_WIDTH-1:0]        err_addr_o,
    output logic [SOURCE_WIDTH-1:0]      err_rrid_o,
    output logic [1:0]                   err_ttype_o,
    output logic                         irq_o
);

    localparam logic [2:0] c_OP_PUT_FULL    = 3'd0;
    localparam logic [2:0] c_OP_PUT_PARTIAL = 3'd1;
    localparam logic [2:0] c_OP_GET         = 3'd4;
    localparam logic [2:0] c_OP_ACK         = 3'd0;
    localparam logic [2:0] c_OP_ACK_DATA    = 3'd1;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RESP = 1'b1
    } state_t;

    state_t                  r_state;
    logic                    r_a_ready;
    logic                    r_d_valid;
    logic [2:0]              r_d_opcode;
    logic [1:0]              r_d_size;
    logic [SOURCE_WIDTH-1:0] r_d_source;
    logic                    r_d_error;

    logic                    w_accept;
    logic                    w_is_get;
    logic                    w_is_put;
    logic [2:0]              w_d_opcode;
    logic                    w_d_error;

    // Decode the incoming request and form the response it will receive.
    always_comb begin
        w_accept   = tl.a_valid & denied_i & (r_state == S_IDLE);
        w_is_get   = (tl.a_opcode == c_OP_GET);
        w_is_put   = (tl.a_opcode == c_OP_PUT_FULL) |
                     (tl.a_opcode == c_OP_PUT_PARTIAL);
        w_d_opcode = w_is_get ? c_OP_ACK_DATA : c_OP_ACK;
        // Unknown opcodes always error, even when responses are suppressed.
        w_d_error  = (w_is_get | w_is_put) ? ~err_cfg_i[1] : 1'b1;
    end

    // Response FSM: accept one denied request, hold the D beat until taken.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_a_ready  <= 1'b1;
            r_d_valid  <= 1'b0;
            r_d_opcode <= '0;
            r_d_size   <= '0;
            r_d_source <= '0;
            r_d_error  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_state    <= S_RESP;
                        r_a_ready  <= 1'b0;
                        r_d_valid  <= 1'b1;
                        r_d_opcode <= w_d_opcode;
                        r_d_size   <= tl.a_size;
                        r_d_source <= tl.a_source;
                        r_d_error  <= w_d_error;
                    end
                end
                S_RESP: begin
                    if (tl.d_ready) begin
                        r_state   <= S_IDLE;
                        r_a_ready <= 1'b1;
                        r_d_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_a_ready <= 1'b1;
                    r_d_valid <= 1'b0;
                end
            endcase
        end
    end

    assign tl.a_ready  = r_a_ready;
    assign tl.d_valid  = r_d_valid;
    assign tl.d_opcode = r_d_opcode;
    assign tl.d_param  = 3'd0;
    assign tl.d_size   = r_d_size;
    assign tl.d_source = r_d_source;
    assign tl.d_sink   = 1'b0;
    assign tl.d_data   = 32'd0;
    assign tl.d_error  = r_d_error;

`ifdef IOPMP_ERR_RECORD_EN
    logic                    r_err_valid;
    logic                    r_err_ovf;
    logic [ADDR_WIDTH-1:0]   r_err_addr;
    logic [SOURCE_WIDTH-1:0] r_err_rrid;
    logic [1:0]              r_err_ttype;

    // Error record: first denial captured, later ones flag overflow; a new
    // capture takes priority over a simultaneous clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_err_valid <= 1'b0;
            r_err_ovf   <= 1'b0;
            r_err_addr  <= '0;
            r_err_rrid  <= '0;
            r_err_ttype <= '0;
        end else if (w_accept && (!r_err_valid || err_clr_i)) begin
            r_err_valid <= 1'b1;
            r_err_ovf   <= 1'b0;
            r_err_addr  <= {{(ADDR_WIDTH-32){1'b0}}, tl.a_address};
            r_err_rrid  <= rrid_i;
            r_err_ttype <= w_is_get ? 2'd1 : 2'd2;
        end else if (w_accept) begin
            r_err_ovf   <= 1'b1;
        end else if (err_clr_i) begin
            r_err_valid <= 1'b0;
            r_err_ovf   <= 1'b0;
        end
    end

    assign err_valid_o = r_err_valid;
    assign err_ovf_o   = r_err_ovf;
    assign err_addr_o  = r_err_addr;
    assign err_rrid_o  = r_err_rrid;
    assign err_ttype_o = r_err_ttype;
    assign irq_o       = r_err_valid & err_cfg_i[0];
`else
    // Record inputs have no consumer when the record is not built.
    wire w_unused_rec = ^{tl.a_address, rrid_i, err_clr_i, err_cfg_i[0]};

    assign err_valid_o = 1'b0;
    assign err_ovf_o   = 1'b0;
    assign err_addr_o  = '0;
    assign err_rrid_o  = '0;
    assign err_ttype_o = 2'd0;
    assign irq_o       = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_iopmp_err_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_iopmp_err_responder
//  Description : Directed self-checking bench for iopmp_err_responder.
//                Record expectations follow IOPMP_ERR_RECORD_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_iopmp_err_responder;

    localparam int AW = 34;
    localparam int SW = 8;
`ifdef IOPMP_ERR_RECORD_EN
    localparam bit REC = 1'b1;
`else
    localparam bit REC = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          denied;
    logic [SW-1:0] rrid;
    logic [1:0]    cfg;
    logic          clr;
    logic          err_valid;
    logic          err_ovf;
    logic [AW-1:0] err_addr;
    logic [SW-1:0] err_rrid;
    logic [1:0]    err_ttype;
    logic          irq;

    int n_vec = 0;
    int n_err = 0;

    iopmp_err_responder_if #(.SOURCE_WIDTH(SW)) tl ();

    iopmp_err_responder #(.ADDR_WIDTH(AW), .SOURCE_WIDTH(SW)) dut (
        .clk         (clk),
        .reset       (reset),
        .tl          (tl),
        .denied_i    (denied),
        .rrid_i      (rrid),
        .err_cfg_i   (cfg),
        .err_clr_i   (clr),
        .err_valid_o (err_valid),
        .err_ovf_o   (err_ovf),
        .err_addr_o  (err_addr),
        .err_rrid_o  (err_rrid),
        .err_ttype_o (err_ttype),
        .irq_o       (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // D channel plus a_ready; a_ready must be the inverse of d_valid.
    task automatic chk_d(input string tag, input bit v, input logic [2:0] op,
                         input bit er, input logic [SW-1:0] src, input logic [1:0] sz);
        chk({tag, ".d_valid"},  64'(tl.d_valid),  64'(v));
        chk({tag, ".a_ready"},  64'(tl.a_ready),  64'(!v));
        chk({tag, ".d_opcode"}, 64'(tl.d_opcode), 64'(op));
        chk({tag, ".d_error"},  64'(tl.d_error),  64'(er));
        chk({tag, ".d_source"}, 64'(tl.d_source), 64'(src));
        chk({tag, ".d_size"},   64'(tl.d_size),   64'(sz));
        chk({tag, ".d_data"},   64'(tl.d_data),   64'd0);
        chk({tag, ".d_param"},  64'(tl.d_param),  64'd0);
        chk({tag, ".d_sink"},   64'(tl.d_sink),   64'd0);
    endtask

    // Error record; contents are only defined while valid is expected.
    task automatic chk_rec(input string tag, input bit v, input bit ovf,
                           input logic [31:0] addr, input logic [SW-1:0] id, input logic [1:0] tt);
        chk({tag, ".err_valid"}, 64'(err_valid), 64'(REC & v));
        chk({tag, ".err_ovf"},   64'(err_ovf),   64'(REC & ovf));
        chk({tag, ".irq"},       64'(irq),       64'(REC & v & cfg[0]));
        if (v) begin
            chk({tag, ".err_addr"},  64'(err_addr),  REC ? 64'(addr) : 64'd0);
            chk({tag, ".err_rrid"},  64'(err_rrid),  REC ? 64'(id) : 64'd0);
            chk({tag, ".err_ttype"}, 64'(err_ttype), REC ? 64'(tt) : 64'd0);
        end
    endtask

    // Present one denied request just after a rising edge; returns just after
    // the accepting edge with the A channel idle again.
    task automatic put_req(input logic [2:0] op, input logic [31:0] addr, input logic [SW-1:0] src,
                           input logic [1:0] sz, input logic [SW-1:0] id, input bit rs);
        tl.a_valid   = 1'b1;
        tl.a_opcode  = op;
        tl.a_address = addr;
        tl.a_source  = src;
        tl.a_size    = sz;
        denied       = 1'b1;
        rrid         = id;
        cfg[1]       = rs;
        @(posedge clk); #1;
        tl.a_valid   = 1'b0;
        denied       = 1'b0;
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
    endtask

    initial begin
        reset        = 1'b1;
        tl.a_valid   = 1'b0;
        tl.a_opcode  = 3'd0;
        tl.a_size    = 2'd0;
        tl.a_source  = '0;
        tl.a_address = 32'd0;
        tl.d_ready   = 1'b1;
        denied       = 1'b0;
        rrid         = '0;
        cfg          = 2'b01;
        clr          = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_d("rst", 1'b0, 3'd0, 1'b0, 8'd0, 2'd0);
        chk("rst.err_addr",  64'(err_addr),  64'd0);
        chk("rst.err_rrid",  64'(err_rrid),  64'd0);
        chk("rst.err_ttype", 64'(err_ttype), 64'd0);
        chk_rec("rst", 1'b0, 1'b0, 32'd0, 8'd0, 2'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Denied Get, rs=0: AccessAckData with error, record captured
        put_req(3'd4, 32'h1000_0040, 8'd3, 2'd2, 8'd2, 1'b0);
        @(negedge clk);
        chk_d("get", 1'b1, 3'd1, 1'b1, 8'd3, 2'd2);
        chk_rec("get", 1'b1, 1'b0, 32'h1000_0040, 8'd2, 2'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("get_done.d_valid", 64'(tl.d_valid), 64'd0);
        chk("get_done.a_ready", 64'(tl.a_ready), 64'd1);
        @(posedge clk); #1;
        pulse_clr();
        @(negedge clk);
        chk_rec("clr1", 1'b0, 1'b0, 32'd0, 8'd0, 2'd0);
        @(posedge clk); #1;

        // Denied PutFull, rs=1: AccessAck without error, ttype write
        put_req(3'd0, 32'h0000_0500, 8'd1, 2'd2, 8'd7, 1'b1);
        @(negedge clk);
        chk_d("putfull", 1'b1, 3'd0, 1'b0, 8'd1, 2'd2);
        chk_rec("putfull", 1'b1, 1'b0, 32'h0000_0500, 8'd7, 2'd2);
        @(posedge clk); #1;

        // Second denial without clear: overflow, record unchanged
        put_req(3'd4, 32'h0000_2000, 8'd2, 2'd2, 8'd9, 1'b0);
        @(negedge clk);
        chk_d("ovf", 1'b1, 3'd1, 1'b1, 8'd2, 2'd2);
        chk_rec("ovf", 1'b1, 1'b1, 32'h0000_0500, 8'd7, 2'd2);
        cfg[0] = 1'b0;
        #1;
        chk("ie_off.irq", 64'(irq), 64'd0);
        cfg[0] = 1'b1;
        @(posedge clk); #1;
        pulse_clr();
        @(negedge clk);
        chk_rec("clr2", 1'b0, 1'b0, 32'd0, 8'd0, 2'd0);
        @(posedge clk); #1;

        // PutPartial with d_ready held low for 5 cycles while another denied
        // request waits on the A channel
        tl.d_ready = 1'b0;
        put_req(3'd1, 32'h0000_0600, 8'd5, 2'd1, 8'd4, 1'b0);
        tl.a_valid  = 1'b1;
        tl.a_opcode = 3'd4;
        tl.a_source = 8'd9;
        denied      = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk_d($sformatf("stall%0d", i), 1'b1, 3'd0, 1'b1, 8'd5, 2'd1);
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk_rec("stall", 1'b1, 1'b0, 32'h0000_0600, 8'd4, 2'd2);
        tl.a_valid = 1'b0;
        denied     = 1'b0;
        tl.d_ready = 1'b1;
        chk_d("stall5", 1'b1, 3'd0, 1'b1, 8'd5, 2'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("stall_done.d_valid", 64'(tl.d_valid), 64'd0);
        chk("stall_done.a_ready", 64'(tl.a_ready), 64'd1);
        @(posedge clk); #1;

        // Unknown opcode with rs=1 still errors; also overflows the record
        put_req(3'd7, 32'h0000_0700, 8'd6, 2'd0, 8'd1, 1'b1);
        @(negedge clk);
        chk_d("badop", 1'b1, 3'd0, 1'b1, 8'd6, 2'd0);
        chk_rec("badop", 1'b1, 1'b1, 32'h0000_0600, 8'd4, 2'd2);
        @(posedge clk); #1;

        // Clear together with a new denial: the capture wins
        clr = 1'b1;
        put_req(3'd0, 32'h0000_3000, 8'd8, 2'd2, 8'd3, 1'b0);
        clr = 1'b0;
        @(negedge clk);
        chk_d("clr_acc", 1'b1, 3'd0, 1'b1, 8'd8, 2'd2);
        chk_rec("clr_acc", 1'b1, 1'b0, 32'h0000_3000, 8'd3, 2'd2);
        @(posedge clk); #1;

        // Reset while a response is pending
        tl.d_ready = 1'b0;
        put_req(3'd4, 32'h0000_4000, 8'd4, 2'd2, 8'd5, 1'b0);
        @(negedge clk);
        chk("rst_resp.pre", 64'(tl.d_valid), 64'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset      = 1'b0;
        tl.d_ready = 1'b1;
        @(negedge clk);
        chk_d("rst_resp", 1'b0, 3'd0, 1'b0, 8'd0, 2'd0);
        chk_rec("rst_resp", 1'b0, 1'b0, 32'd0, 8'd0, 2'd0);
        chk("rst_resp.err_addr", 64'(err_addr), 64'd0);
        @(posedge clk); #1;

        // a_valid without denied_i is ignored
        tl.a_valid  = 1'b1;
        tl.a_opcode = 3'd4;
        denied      = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk($sformatf("nodeny%0d.d_valid", i), 64'(tl.d_valid), 64'd0);
            chk($sformatf("nodeny%0d.a_ready", i), 64'(tl.a_ready), 64'd1);
            chk($sformatf("nodeny%0d.err_valid", i), 64'(err_valid), 64'd0);
            @(posedge clk); #1;
        end
        tl.a_valid = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/iopmp_err_responder.md
# iopmp_err_responder

Per-channel TL-UL error termination stage sitting directly downstream of the IOPMP request handler. Sinks every A-channel request the handler flags as permission-denied, returns a single-beat D-channel response shaped by `ERR_CFG`, and latches the first violation into an error record with a level interrupt. Permitted traffic never reaches this block; the handler routes it to the slave port.

## Interface
- `AddrWidth`, 34, width of the error-record address; the TL-UL `a_address` is zero-extended into it.
- `clk`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-high.
- `req_i`  in  tl_h2d_t  denied-path A channel from the request handler (`a_valid`, `a_opcode`, `a_size`, `a_source`, `a_address`, `d_ready` used).
- `denied_i`  in  1  qualifies `req_i.a_valid`; a request is taken only when both are high.
- `rrid_i`  in  SourceWidth  requester ID of the current request.
- `err_cfg_i`  in  iopmp_pkg::err_cfg  uses `ie` (interrupt enable) and `rs` (response suppress).
- `rsp_o`  out  tl_d2h_t  D channel toward the master, plus `a_ready`.
- `err_clr_i`  in  1  single-cycle clear of the error record.
- `err_valid_o`  out  1  error record holds a capture.
- `err_ovf_o`  out  1  sticky: a further denial occurred while `err_valid_o` was set.
- `err_addr_o`  out  AddrWidth  captured address.
- `err_rrid_o`  out  SourceWidth  captured RRID.
- `err_ttype_o`  out  2  captured transaction type: 1 read, 2 write.
- `irq_o`  out  1  `err_valid_o & err_cfg_i.ie`.

## Operation
- FSM states are IDLE and RESP.
- IDLE:
  - `rsp_o.a_ready`=1, `d_valid`=0.
  - Accept is `a_valid & denied_i`. On accept, register `a_source`, `a_size`, the response opcode and the error flag, then go to RESP.
- RESP:
  - `a_ready`=0, `d_valid`=1. All D fields are held stable until the D handshake `d_valid & d_ready`, then return to IDLE.
- D fields:
  - `d_opcode` is AccessAckData (1) for Get (4) and AccessAck (0) for PutFull (0) or PutPartial (1).
  - `d_data`=0, `d_param`=0, `d_sink`=0. `d_source` and `d_size` echo the request.
  - `d_error` = ~`rs` for Get and Put opcodes. Any other opcode gets AccessAck with `d_error`=1 regardless of `rs`.
- Error record capture, on accept:
  - If `err_valid` is 0: load addr, rrid, and ttype (Get→1, else 2), then set `err_valid`.
  - If `err_valid` is 1: record unchanged, set `err_ovf`.
- Error record clear:
  - `err_clr_i` clears `err_valid` and `err_ovf`.
  - Clear and accept in the same cycle: the new capture wins, so `err_valid`=1 with the new data and `err_ovf`=0.
- `err_cfg_i` is sampled at accept for `rs`. `ie` applies combinationally to `irq_o`.

## Timing
- Reset values:
  - FSM is IDLE, `a_ready`=1.
  - All D fields are 0.
  - `err_valid`, `err_ovf`, `err_addr`, `err_rrid` and `err_ttype` are 0, and `irq_o`=0.
- Latency: `d_valid` rises the cycle after the A handshake.
- Throughput: at most one request per 2 cycles. `a_ready` is low throughout RESP and there is no combinational `d_ready`→`a_ready` path.
- Record outputs update the cycle after accept or clear.
- `reset` asserted in RESP: at that edge the FSM goes to IDLE, `d_valid` drops and the pending response is discarded.
- `a_valid` with `denied_i`=0: ignored. `a_ready` stays as the state dictates.

## Configuration
- Macro: `IOPMP_ERR_RECORD_EN`.
- Defined: error record, overflow flag and `irq_o` are implemented as above.
- Undefined:
  - No record registers are built.
  - `err_valid_o`, `err_ovf_o`, `err_addr_o`, `err_rrid_o`, `err_ttype_o` and `irq_o` are tied to 0, and `err_clr_i` is ignored.
  - D-channel behaviour is unchanged.

## Test plan
- Denied Get, addr 0x1000_0040, source 3, rrid 2, `rs`=0, `d_ready`=1 → next cycle D is AccessAckData, `d_error`=1, `d_data`=0, `d_source`=3. The record is addr 0x0_1000_0040, rrid 2, ttype 1; with `ie`=1, `irq_o`=1.
- Denied PutFull with `rs`=1 → AccessAck with `d_error`=0. ttype captured as 2.
- Two denials without clear, the second at addr 0x2000 → record still holds the first, `err_ovf_o`=1. Then pulse `err_clr_i` → both flags 0.
- Hold `d_ready`=0 for 5 cycles in RESP → D fields stable and `a_ready`=0 throughout. Handshake on cycle 6, then back in IDLE.
- `err_clr_i` in the same cycle as a new denial at addr 0x3000 → `err_valid_o`=1, `err_addr_o`=0x3000, `err_ovf_o`=0.
- Assert `reset` while in RESP → `d_valid`=0 and `a_ready`=1 the next cycle, and the record is cleared. Then build without `IOPMP_ERR_RECORD_EN` → all record outputs and `irq_o` are 0 for any denial.
